dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning the word-address width of the shared data memory.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive lost arbitrations on port 1 before a forced grant (range 1-15).
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N, input, 1, the reset: synchronous, active-low.
REQ-005 SHALL have ports M0_VALID / M1_VALID, input, 1 each, meaning the requester has an access pending.
REQ-006 SHALL have ports M0_READY / M1_READY, output, 1 each, meaning the access is granted this cycle.
REQ-007 SHALL have ports M0_ADDR / M1_ADDR, input, ADDR_WIDTH each, meaning the word address.
REQ-008 SHALL have ports M0_WSTRB / M1_WSTRB, input, 4 each, meaning the byte write strobes; all-zero means read.
REQ-009 SHALL have ports M0_WDATA / M1_WDATA, input, 32 each, meaning the write data.
REQ-010 SHALL have ports M0_RVALID / M1_RVALID, output, 1 each, meaning a response pulse for the access granted one cycle earlier.
REQ-011 SHALL have ports M0_RDATA / M1_RDATA, output, 32 each, meaning the response data, valid only while the matching RVALID is high.
REQ-012 SHALL have memory-side ports MEM_EN (out,1), MEM_WE (out,4), MEM_ADDR (out,ADDR_WIDTH), MEM_WDATA (out,32) and MEM_RDATA (in,32), connecting to a single-port synchronous RAM with one-cycle read latency and read-old-data-on-write.

Function
REQ-013 SHALL define a transfer on port x as Mx_VALID && Mx_READY in the same cycle.
REQ-014 SHALL require a requester to hold ADDR/WSTRB/WDATA stable while VALID is high and not yet granted; the arbiter SHALL NOT require VALID to stay high after a transfer.
REQ-015 SHALL generate READY combinationally from the current VALIDs and registered arbitration state; at most one READY high per cycle.
REQ-016 SHALL use fixed priority: M0 wins when both VALIDs are high, except as REQ-026 overrides.
REQ-017 SHALL drive, in a grant cycle, MEM_EN=1, MEM_ADDR/MEM_WDATA from the winner, and MEM_WE equal to the winner's WSTRB.
REQ-018 SHALL drive MEM_EN=0 and MEM_WE=4'b0000 when no port is granted; MEM_ADDR/MEM_WDATA are then don't-care.
REQ-019 SHALL register the grant owner and assert Mx_RVALID exactly one cycle after Mx's transfer, for one cycle per transfer.
REQ-020 SHALL route MEM_RDATA to the owner's RDATA while its RVALID is high; on writes, RDATA is the pre-write word.
REQ-021 SHALL sustain one transfer per cycle: back-to-back grants (either port, any read/write mix) with no bubble.
REQ-022 SHALL keep a 4-bit starvation counter: +1 on each cycle M1_VALID=1 and M0 is granted; cleared on an M1 grant or when M1_VALID=0; saturating at 15.
REQ-023 SHALL treat a write with partial WSTRB (e.g. 4'b0101) as writing only the strobed bytes, passed unchanged on MEM_WE.
REQ-024 SHALL, with a single VALID, grant it in the same cycle regardless of counter state.

Reset
REQ-025 SHALL, while RST_N=0 at a rising edge: clear RVALIDs, owner, and starvation counter; while RST_N=0, force both READY=0, MEM_EN=0, MEM_WE=0; any response pending at reset is dropped (no RVALID after reset release).

Configuration
REQ-026 SHALL honour macro DMEM_ARB_STARVE_EN: when defined, once the counter reaches STARVE_LIMIT and both VALIDs are high, M1 is granted and the counter clears; when undefined, the counter is not implemented and M0 strictly always wins.

Verification
REQ-027 SHALL cover: M0 read addr 0x010 (RAM=0xDEADBEEF) -> M0_READY same cycle, MEM_EN=1, M0_RVALID next cycle with M0_RDATA=0xDEADBEEF.
REQ-028 SHALL cover: M1 write addr 0x020 WSTRB=4'b0011 WDATA=0x12345678 over 0xAAAAAAAA, then read -> MEM_WE=4'b0011, readback 0xAAAA5678.
REQ-029 SHALL cover: both VALID held 6 cycles, STARVE_LIMIT=4, macro defined -> grants M0,M0,M0,M0,M1,M0; macro undefined -> six M0 grants, M1_READY never high.
REQ-030 SHALL cover: alternating M0/M1 reads at addresses 1..8 every cycle -> 8 grants in 8 cycles, each RVALID one cycle later on the correct port with correct data.
REQ-031 SHALL cover: RST_N low in the cycle after an M0 read grant -> M0_RVALID stays 0, READY/MEM_EN 0 during reset, counter 0 after release.
REQ-032 SHALL cover: idle (no VALID) for 3 cycles -> MEM_EN=0, MEM_WE=0, no RVALID, RAM contents unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of a single-port synchronous data RAM; M0 has fixed priority, one access per cycle.
// Optional starvation guard for M1 is enabled with `define DMEM_ARB_STARVE_EN (the default build has M0 strictly winning).
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  M0_VALID,
  output logic                  M0_READY,
  input  logic [ADDR_WIDTH-1:0] M0_ADDR,
  input  logic [3:0]            M0_WSTRB,
  input  logic [31:0]           M0_WDATA,
  output logic                  M0_RVALID,
  output logic [31:0]           M0_RDATA,
  input  logic                  M1_VALID,
  output logic                  M1_READY,
  input  logic [ADDR_WIDTH-1:0] M1_ADDR,
  input  logic [3:0]            M1_WSTRB,
  input  logic [31:0]           M1_WDATA,
  output logic                  M1_RVALID,
  output logic [31:0]           M1_RDATA,
  output logic                  MEM_EN,
  output logic [3:0]            MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [31:0]           MEM_WDATA,
  input  logic [31:0]           MEM_RDATA
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("dmem_arbiter: STARVE_LIMIT must be in 1..15");
  end

  logic gnt0;
  logic gnt1;
  logic rv0_q;
  logic rv1_q;

`ifdef DMEM_ARB_STARVE_EN
  logic [3:0] starve_cnt;
  logic       force_m1;

  assign force_m1 = (starve_cnt >= 4'(STARVE_LIMIT));

  always_comb begin
    gnt0 = RST_N & M0_VALID & ~(M1_VALID & force_m1);
    gnt1 = RST_N & M1_VALID & (~M0_VALID | force_m1);
  end

  // Counts cycles M1 waits behind M0; any M1 grant or M1 withdrawing restarts it.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      starve_cnt <= 4'd0;
    end else if (gnt1 || !M1_VALID) begin
      starve_cnt <= 4'd0;
    end else if (gnt0 && starve_cnt != 4'hF) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  always_comb begin
    gnt0 = RST_N & M0_VALID;
    gnt1 = RST_N & M1_VALID & ~M0_VALID;
  end
`endif

  assign M0_READY  = gnt0;
  assign M1_READY  = gnt1;

  assign MEM_EN    = gnt0 | gnt1;
  assign MEM_WE    = gnt0 ? M0_WSTRB : (gnt1 ? M1_WSTRB : 4'b0000);
  assign MEM_ADDR  = gnt1 ? M1_ADDR  : M0_ADDR;
  assign MEM_WDATA = gnt1 ? M1_WDATA : M0_WDATA;

  // Response owner: the RAM returns data one cycle after the grant.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
    end else begin
      rv0_q <= gnt0;
      rv1_q <= gnt1;
    end
  end

  // Gating with RST_N drops a response that was in flight when reset arrived.
  assign M0_RVALID = rv0_q & RST_N;
  assign M1_RVALID = rv1_q & RST_N;
  assign M0_RDATA  = M0_RVALID ? MEM_RDATA : 32'h0;
  assign M1_RDATA  = M1_RVALID ? MEM_RDATA : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port RAM (1-cycle read, read-old-on-write, byte strobes).
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        M0_VALID, M1_VALID;
  logic        M0_READY, M1_READY;
  logic [9:0]  M0_ADDR, M1_ADDR;
  logic [3:0]  M0_WSTRB, M1_WSTRB;
  logic [31:0] M0_WDATA, M1_WDATA;
  logic        M0_RVALID, M1_RVALID;
  logic [31:0] M0_RDATA, M1_RDATA;
  logic        MEM_EN;
  logic [3:0]  MEM_WE;
  logic [9:0]  MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;

  logic [31:0] ram [0:1023];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_dat;

  int vectors = 0;
  int miscompares = 0;

  logic [5:0] exp_starve6;
  logic [4:0] exp_starve5;

  always #5 CLK = ~CLK;

  dmem_arbiter #(.ADDR_WIDTH(10), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .M0_VALID(M0_VALID), .M0_READY(M0_READY), .M0_ADDR(M0_ADDR), .M0_WSTRB(M0_WSTRB),
    .M0_WDATA(M0_WDATA), .M0_RVALID(M0_RVALID), .M0_RDATA(M0_RDATA),
    .M1_VALID(M1_VALID), .M1_READY(M1_READY), .M1_ADDR(M1_ADDR), .M1_WSTRB(M1_WSTRB),
    .M1_WDATA(M1_WDATA), .M1_RVALID(M1_RVALID), .M1_RDATA(M1_RDATA),
    .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA)
  );

  always @(posedge CLK) begin
    if (pre_we) begin
      ram[pre_addr] <= pre_dat;
    end else if (MEM_EN) begin
      MEM_RDATA <= ram[MEM_ADDR];
      for (int b = 0; b < 4; b++)
        if (MEM_WE[b]) ram[MEM_ADDR][b*8 +: 8] <= MEM_WDATA[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [9:0] a0, input logic [3:0] s0, input logic [31:0] d0,
                       input logic v1, input logic [9:0] a1, input logic [3:0] s1, input logic [31:0] d1);
    M0_VALID = v0; M0_ADDR = a0; M0_WSTRB = s0; M0_WDATA = d0;
    M1_VALID = v1; M1_ADDR = a1; M1_WSTRB = s1; M1_WDATA = d1;
  endtask

  task automatic nxt;
    @(negedge CLK);
  endtask

  initial begin
`ifdef DMEM_ARB_STARVE_EN
    exp_starve6 = 6'b010000;
    exp_starve5 = 5'b10000;
`else
    exp_starve6 = 6'b000000;
    exp_starve5 = 5'b00000;
`endif
    RST_N = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
    drive(1'b1, 10'h010, 4'hF, 32'h0, 1'b1, 10'h020, 4'hF, 32'h0);

    // Reset: preload RAM one word per cycle while checking that nothing is granted
    for (int i = 0; i < 12; i++) begin
      nxt();
      pre_we = 1'b1;
      case (i)
        0:       begin pre_addr = 10'h010; pre_dat = 32'hDEADBEEF; end
        1:       begin pre_addr = 10'h020; pre_dat = 32'hAAAAAAAA; end
        2:       begin pre_addr = 10'h030; pre_dat = 32'h55555555; end
        default: begin pre_addr = 10'(i - 2); pre_dat = 32'h10000000 + 32'(i - 2); end
      endcase
      #1;
      if (i < 2) begin
        chk("rst_m0_ready", {31'b0, M0_READY}, 32'd0);
        chk("rst_m1_ready", {31'b0, M1_READY}, 32'd0);
        chk("rst_mem_en", {31'b0, MEM_EN}, 32'd0);
        chk("rst_mem_we", {28'b0, MEM_WE}, 32'd0);
        chk("rst_rvalid", {30'b0, M1_RVALID, M0_RVALID}, 32'd0);
      end
    end
    nxt();
    pre_we = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    RST_N = 1'b1;

    // M0 read of 0x010
    nxt();
    drive(1'b1, 10'h010, 4'h0, 32'h0, 1'b0, '0, '0, '0);
    #1;
    chk("rd_m0_ready", {31'b0, M0_READY}, 32'd1);
    chk("rd_m1_ready", {31'b0, M1_READY}, 32'd0);
    chk("rd_mem_en", {31'b0, MEM_EN}, 32'd1);
    chk("rd_mem_addr", {22'b0, MEM_ADDR}, 32'h010);
    chk("rd_mem_we", {28'b0, MEM_WE}, 32'd0);
    nxt();
    chk("rd_m0_rvalid", {31'b0, M0_RVALID}, 32'd1);
    chk("rd_m0_rdata", M0_RDATA, 32'hDEADBEEF);
    chk("rd_m1_rvalid", {31'b0, M1_RVALID}, 32'd0);
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    #1;
    chk("idle_mem_en", {31'b0, MEM_EN}, 32'd0);
    nxt();
    chk("rd_rvalid_once", {31'b0, M0_RVALID}, 32'd0);

    // M1 partial write then read-back
    drive(1'b0, '0, '0, '0, 1'b1, 10'h020, 4'b0011, 32'h12345678);
    #1;
    chk("wr_m1_ready", {31'b0, M1_READY}, 32'd1);
    chk("wr_mem_we", {28'b0, MEM_WE}, 32'h3);
    chk("wr_mem_wdata", MEM_WDATA, 32'h12345678);
    chk("wr_mem_addr", {22'b0, MEM_ADDR}, 32'h020);
    nxt();
    chk("wr_m1_rvalid", {31'b0, M1_RVALID}, 32'd1);
    chk("wr_old_data", M1_RDATA, 32'hAAAAAAAA);
    drive(1'b0, '0, '0, '0, 1'b1, 10'h020, 4'b0000, 32'h0);
    nxt();
    chk("wr_readback", M1_RDATA, 32'hAAAA5678);
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    nxt();

    // Both requesters held for 6 cycles
    drive(1'b1, 10'h001, 4'h0, 32'h0, 1'b1, 10'h002, 4'h0, 32'h0);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("starve_m1_ready_%0d", c), {31'b0, M1_READY}, {31'b0, exp_starve6[c]});
      chk($sformatf("starve_m0_ready_%0d", c), {31'b0, M0_READY}, {31'b0, ~exp_starve6[c]});
      nxt();
    end
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    nxt();

    // Alternating single-port reads of addresses 1..8, one per cycle
    for (int i = 1; i <= 9; i++) begin
      if (i > 1) begin
        chk($sformatf("alt_rvalid_%0d", i - 1), {30'b0, M1_RVALID, M0_RVALID},
            ((i - 1) % 2 == 1) ? 32'd1 : 32'd2);
        chk($sformatf("alt_rdata_%0d", i - 1), ((i - 1) % 2 == 1) ? M0_RDATA : M1_RDATA,
            32'h10000000 + 32'(i - 1));
      end
      if (i <= 8) begin
        if (i % 2 == 1) drive(1'b1, 10'(i), 4'h0, 32'h0, 1'b0, '0, '0, '0);
        else            drive(1'b0, '0, '0, '0, 1'b1, 10'(i), 4'h0, 32'h0);
        #1;
        chk($sformatf("alt_ready_%0d", i), {30'b0, M1_READY, M0_READY},
            (i % 2 == 1) ? 32'd1 : 32'd2);
        nxt();
      end else begin
        drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
      end
    end
    nxt();

    // Reset right after an M0 read grant, with the starvation count part-way up
    drive(1'b1, 10'h010, 4'h0, 32'h0, 1'b1, 10'h002, 4'h0, 32'h0);
    nxt(); nxt();
    #1;
    chk("prerst_m0_ready", {31'b0, M0_READY}, 32'd1);
    nxt();
    RST_N = 1'b0;
    drive(1'b1, 10'h010, 4'hF, 32'hFFFFFFFF, 1'b1, 10'h020, 4'hF, 32'hFFFFFFFF);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("rst2_m0_rvalid", {31'b0, M0_RVALID}, 32'd0);
      chk("rst2_ready", {30'b0, M1_READY, M0_READY}, 32'd0);
      chk("rst2_mem_en", {31'b0, MEM_EN}, 32'd0);
      chk("rst2_mem_we", {28'b0, MEM_WE}, 32'd0);
      nxt();
    end
    RST_N = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    nxt();
    chk("postrst_rvalid", {30'b0, M1_RVALID, M0_RVALID}, 32'd0);
    drive(1'b1, 10'h001, 4'h0, 32'h0, 1'b1, 10'h002, 4'h0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("postrst_m1_ready_%0d", c), {31'b0, M1_READY}, {31'b0, exp_starve5[c]});
      nxt();
    end
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    nxt();

    // Idle for three cycles, strobes left asserted
    M0_WSTRB = 4'hF; M1_WSTRB = 4'hF; M0_ADDR = 10'h030; M1_ADDR = 10'h030;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("idle3_mem_en", {31'b0, MEM_EN}, 32'd0);
      chk("idle3_mem_we", {28'b0, MEM_WE}, 32'd0);
      chk("idle3_rvalid", {30'b0, M1_RVALID, M0_RVALID}, 32'd0);
      nxt();
    end
    chk("ram_030", ram[10'h030], 32'h55555555);
    chk("ram_010", ram[10'h010], 32'hDEADBEEF);
    chk("ram_020", ram[10'h020], 32'hAAAA5678);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
